// File: rtl/bignum_stream_port_if.sv
// bignum_stream_port_if: command, operand/result stream, adder handshake and SRAM bus of the stream port.
interface bignum_stream_port_if #(parameter int ADRBW = 20, parameter int WRDBW = 16, parameter int VARBW = 17);
  logic             i_start;
  logic             i_sub;
  logic [VARBW-1:0] i_varsize;
  logic [ADRBW-1:0] i_x1addr;
  logic [ADRBW-1:0] i_x2addr;
  logic [ADRBW-1:0] i_x3addr;
  logic             o_busy;
  logic             i_in_valid;
  logic [WRDBW-1:0] i_in_data;
  logic             o_in_ready;
  logic             o_out_valid;
  logic [WRDBW-1:0] o_out_data;
  logic             i_out_ready;
  logic             o_calc_valid;
  logic             o_calc_sub;
  logic             i_calc_done;
  logic             o_own;
  logic             o_wen;
  logic [ADRBW-1:0] o_addr;
  logic [WRDBW-1:0] o_wdata;
  logic [WRDBW-1:0] i_rdata;
  modport slave (
    input  i_start, i_sub, i_varsize, i_x1addr, i_x2addr, i_x3addr, i_in_valid, i_in_data,
           i_out_ready, i_calc_done, i_rdata,
    output o_busy, o_in_ready, o_out_valid, o_out_data, o_calc_valid, o_calc_sub, o_own,
           o_wen, o_addr, o_wdata
  );
  modport master (
    output i_start, i_sub, i_varsize, i_x1addr, i_x2addr, i_x3addr, i_in_valid, i_in_data,
           i_out_ready, i_calc_done, i_rdata,
    input  o_busy, o_in_ready, o_out_valid, o_out_data, o_calc_valid, o_calc_sub, o_own,
           o_wen, o_addr, o_wdata
  );
endinterface

// File: rtl/bignum_stream_port.sv
// bignum_stream_port: loads x1/x2 into SRAM from a word stream, fires the adder, streams x3 back out.
module bignum_stream_port #(parameter int ADRBW = 20, parameter int WRDBW = 16, parameter int VARBW = 17) (
  input logic              i_clk,
  input logic              i_rst,
  bignum_stream_port_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, KICK, WAIT, READ, SEND} state_t;
  state_t           state_q, state_d;
  logic [VARBW-1:0] cnt_q, cnt_d, n_q, n_d;
  logic [ADRBW-1:0] base_q, base_d, x2_q, x2_d, x3_q, x3_d;
  logic [WRDBW-1:0] out_q, out_d;
  logic             sub_q, sub_d, first_q, first_d;
  logic             load, in_hs, out_hs, last_in;
  assign load    = state_q == LOAD1 || state_q == LOAD2;
  assign in_hs   = load && bus.i_in_valid;
  assign out_hs  = state_q == SEND && bus.i_out_ready;
  assign last_in = cnt_q == n_q - VARBW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    base_d  = base_q;
    x2_d    = x2_q;
    x3_d    = x3_q;
    out_d   = out_q;
    sub_d   = sub_q;
    first_d = state_q == KICK;
    case (state_q)
      IDLE: if (bus.i_start && bus.i_varsize != '0) begin
        state_d = LOAD1;
        cnt_d   = '0;
        n_d     = VARBW'(({1'b0, bus.i_varsize} + (VARBW+1)'(WRDBW - 1)) / (VARBW+1)'(WRDBW));
        base_d  = bus.i_x1addr;
        x2_d    = bus.i_x2addr;
        x3_d    = bus.i_x3addr;
        sub_d   = bus.i_sub;
      end
      LOAD1: if (in_hs) begin
        cnt_d   = last_in ? '0 : cnt_q + VARBW'(1);
        state_d = last_in ? LOAD2 : LOAD1;
        base_d  = last_in ? x2_q : base_q;
      end
      LOAD2: if (in_hs) begin
        cnt_d   = cnt_q + VARBW'(1);
        state_d = last_in ? KICK : LOAD2;
      end
      KICK: state_d = WAIT;
      // the adder still reports idle in the first WAIT cycle, so done is only trusted afterwards
      WAIT: if (!first_q && bus.i_calc_done) begin
        state_d = READ;
        cnt_d   = '0;
      end
      READ: begin
        out_d   = bus.i_rdata;
        state_d = SEND;
      end
      SEND: if (out_hs) begin
        cnt_d   = cnt_q + VARBW'(1);
        state_d = cnt_q == n_q ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      base_q  <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      out_q   <= '0;
      sub_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      base_q  <= base_d;
      x2_q    <= x2_d;
      x3_q    <= x3_d;
      out_q   <= out_d;
      sub_q   <= sub_d;
      first_q <= first_d;
    end
  end
  assign bus.o_busy       = state_q != IDLE;
  assign bus.o_in_ready   = load;
  assign bus.o_out_valid  = state_q == SEND;
  assign bus.o_out_data   = out_q;
  assign bus.o_calc_valid = state_q == KICK;
  assign bus.o_calc_sub   = sub_q;
  assign bus.o_own        = !(state_q == KICK || state_q == WAIT);
  assign bus.o_wen        = in_hs;
  assign bus.o_wdata      = in_hs ? bus.i_in_data : '0;
  assign bus.o_addr       = load ? base_q + ADRBW'(cnt_q)
                          : (state_q == READ || state_q == SEND) ? x3_q + ADRBW'(cnt_q) : '0;
endmodule

// File: tb/tb_bignum_stream_port.sv
// tb_bignum_stream_port: random commands against a word-list model of the load/add/stream protocol,
// with a bench SRAM and a delayed big-integer adder model.
module tb_bignum_stream_port;
  localparam int ADRBW = 20, WRDBW = 16, VARBW = 17;
  typedef logic [15:0] wv_t [9];
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  bignum_stream_port_if #(.ADRBW(ADRBW), .WRDBW(WRDBW), .VARBW(VARBW)) bus ();
  bignum_stream_port #(.ADRBW(ADRBW), .WRDBW(WRDBW), .VARBW(VARBW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // operands are unsigned n-word numbers; result is (a +/- b) mod 2^(16*(n+1))
  function automatic wv_t calc(input wv_t a, input wv_t b, input logic sub, input int n);
    wv_t r;
    logic [16:0] s;
    logic c;
    c = sub;
    for (int i = 0; i < 9; i++) r[i] = '0;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, a[i]} + {1'b0, sub ? ~b[i] : b[i]} + 17'(c);
      r[i] = s[15:0];
      c = s[16];
    end
    r[n] = sub ? (c ? 16'h0000 : 16'hFFFF) : {15'h0, c};
    return r;
  endfunction
  logic [15:0] mem [0:4095];
  int bcnt = 0, dly = 0;
  int cx1 = 0, cx2 = 0, cx3 = 0, cn = 0, sent = 0, calcs = 0, ownlow = 0, litm = 0, lit = 0;
  bit active = 0, rst_chk = 0, pinned = 0;
  logic csub = 1'b0;
  wv_t op1, op2;
  int wa[$];
  logic [15:0] wd[$], outq[$], cap[$];
  assign bus.i_rdata = mem[bus.o_addr[11:0]];
  assign bus.i_calc_done = bcnt == 0;
  always @(posedge clk) begin : sram_adder
    wv_t a, b, r;
    if (bus.o_own && bus.o_wen) mem[bus.o_addr[11:0]] <= bus.o_wdata;
    if (rst) bcnt <= 0;
    else if (bus.o_calc_valid) begin
      for (int i = 0; i < 9; i++) begin
        a[i] = i < cn ? mem[12'(cx1 + i)] : 16'h0;
        b[i] = i < cn ? mem[12'(cx2 + i)] : 16'h0;
      end
      r = calc(a, b, bus.o_calc_sub, cn);
      for (int i = 0; i <= cn; i++) mem[12'(cx3 + i)] <= r[i];
      bcnt <= dly;
    end else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  always @(negedge clk) begin : compare
    wv_t pa, pb, e;
    bit was;
    if (!pinned) begin
      pinned = 1;
      for (int i = 0; i < 9; i++) begin pa[i] = '0; pb[i] = '0; end
      pa[0] = 16'hFFFF; pa[1] = 16'h0001; pb[0] = 16'h0001;
      e = calc(pa, pb, 1'b0, 2);
      chk("pin_add0", 32'(e[0]), 32'h0000); chk("pin_add1", 32'(e[1]), 32'h0002); chk("pin_add2", 32'(e[2]), 32'h0000);
      pa[0] = 16'h0005; pa[1] = 16'h0000; pb[0] = 16'h0007;
      e = calc(pa, pb, 1'b1, 2);
      chk("pin_sub0", 32'(e[0]), 32'hFFFE); chk("pin_sub1", 32'(e[1]), 32'hFFFF); chk("pin_sub2", 32'(e[2]), 32'hFFFF);
    end
    if (rst) begin
      rst_chk = 1; active = 0; ownlow = 0;
      wa.delete(); wd.delete(); outq.delete(); cap.delete();
    end else begin
      if (rst_chk) begin
        rst_chk = 0;
        chk("rst_busy", 32'(bus.o_busy), 0); chk("rst_in_ready", 32'(bus.o_in_ready), 0);
        chk("rst_out_valid", 32'(bus.o_out_valid), 0); chk("rst_out_data", 32'(bus.o_out_data), 0);
        chk("rst_calc_valid", 32'(bus.o_calc_valid), 0); chk("rst_calc_sub", 32'(bus.o_calc_sub), 0);
        chk("rst_own", 32'(bus.o_own), 1); chk("rst_wen", 32'(bus.o_wen), 0);
        chk("rst_addr", 32'(bus.o_addr), 0); chk("rst_wdata", 32'(bus.o_wdata), 0);
      end
      was = active;
      chk("busy", 32'(bus.o_busy), 32'(active));
      chk("wen_on_handshake", 32'(bus.o_wen), 32'(bus.i_in_valid && bus.o_in_ready));
      if (bus.o_wen) begin
        if (wa.size() == 0) chk("write_extra", 1, 0);
        else begin
          chk("write_addr", 32'(bus.o_addr), 32'(wa.pop_front()));
          chk("write_data", 32'(bus.o_wdata), 32'(wd.pop_front()));
        end
      end
      if (!bus.o_own) begin
        ownlow++;
        chk("unowned_quiet", {29'h0, bus.o_in_ready, bus.o_out_valid, bus.o_wen}, 0);
        chk("unowned_addr", 32'(bus.o_addr), 0);
      end else if (ownlow > 0) begin
        chk("unowned_cycles", 32'(ownlow), 32'((dly < 1 ? 1 : dly) + 2));
        ownlow = 0;
      end
      if (bus.o_calc_valid) begin
        calcs++;
        chk("calc_sub", 32'(bus.o_calc_sub), 32'(csub));
        chk("calc_after_load", 32'(wa.size()), 0);
      end
      if (!active) begin
        chk("idle_addr", 32'(bus.o_addr), 0);
        chk("idle_own", 32'(bus.o_own), 1);
      end
      if (bus.o_out_valid) begin
        if (outq.size() == 0) chk("out_extra", 1, 0);
        else begin
          chk("out_addr", 32'(bus.o_addr), 32'(cx3 + sent));
          chk("out_data", 32'(bus.o_out_data), 32'(outq[0]));
          if (bus.i_out_ready) begin
            cap.push_back(bus.o_out_data);
            void'(outq.pop_front());
            sent++;
            if (outq.size() == 0) begin
              active = 0;
              chk("calc_pulses", 32'(calcs), 1);
              if (litm == 1) begin
                chk("lit_add_cnt", 32'(cap.size()), 3);
                chk("lit_add0", 32'(cap[0]), 32'h0000); chk("lit_add1", 32'(cap[1]), 32'h0002); chk("lit_add2", 32'(cap[2]), 32'h0000);
              end
              if (litm == 2) begin
                chk("lit_sub_cnt", 32'(cap.size()), 3);
                chk("lit_sub0", 32'(cap[0]), 32'hFFFE); chk("lit_sub1", 32'(cap[1]), 32'hFFFF); chk("lit_sub2", 32'(cap[2]), 32'hFFFF);
              end
            end
          end
        end
      end
      if (!was && bus.i_start && bus.i_varsize != '0) begin
        cx1 = int'(bus.i_x1addr); cx2 = int'(bus.i_x2addr); cx3 = int'(bus.i_x3addr);
        csub = bus.i_sub; cn = (int'(bus.i_varsize) + 15) / 16;
        sent = 0; calcs = 0; litm = lit; cap.delete(); active = 1;
        for (int i = 0; i < cn; i++) begin wa.push_back(cx1 + i); wd.push_back(op1[i]); end
        for (int i = 0; i < cn; i++) begin wa.push_back(cx2 + i); wd.push_back(op2[i]); end
        e = calc(op1, op2, csub, cn);
        for (int i = 0; i <= cn; i++) outq.push_back(e[i]);
      end
    end
  end
  task automatic rand_ops();
    for (int i = 0; i < 9; i++) begin op1[i] = 16'($urandom); op2[i] = 16'($urandom); end
  endtask
  // gap: 0 = valid every cycle, 1 = valid toggling, 2 = random; bp: hold ready low 5 cycles on word 1
  task automatic run(input logic sub, input int vs, input int gap, input int bp, input int d,
                     input bit busy_start, input bit abort);
    int n, k, t, st;
    logic hs;
    n = (vs + 15) / 16;
    dly = d;
    bus.i_start = 1'b1; bus.i_sub = sub; bus.i_varsize = VARBW'(vs);
    bus.i_x1addr = ADRBW'($urandom_range(0, 1000));
    bus.i_x2addr = ADRBW'(1024 + $urandom_range(0, 1000));
    bus.i_x3addr = ADRBW'(2048 + $urandom_range(0, 1000));
    @(posedge clk); #1;
    bus.i_start = busy_start; bus.i_sub = ~sub; bus.i_varsize = VARBW'(vs + 40);
    bus.i_x1addr = bus.i_x1addr + ADRBW'(3); bus.i_x2addr = bus.i_x2addr + ADRBW'(5); bus.i_x3addr = bus.i_x3addr + ADRBW'(7);
    k = 0; t = 0;
    while (k < 2 * n) begin
      if (abort && k == n + 1) begin
        bus.i_in_valid = 1'b0; bus.i_start = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        return;
      end
      bus.i_in_valid = gap == 0 ? 1'b1 : gap == 1 ? t[0] : ($urandom_range(0, 2) != 0);
      bus.i_in_data = k < n ? op1[k] : op2[k - n];
      hs = bus.i_in_valid && bus.o_in_ready;
      @(posedge clk); #1;
      if (hs) k++;
      t++;
      if (t > 2000) begin $display("FAIL load_timeout: accepted %0d of %0d words", k, 2 * n); $fatal(1); end
    end
    bus.i_in_valid = 1'b0; bus.i_start = 1'b0;
    st = 0; t = 0;
    while (active) begin
      if (bp != 0) begin
        bus.i_out_ready = !(bus.o_out_valid && sent == 1 && st < 5);
        if (bus.o_out_valid && sent == 1 && st < 5) st++;
      end else bus.i_out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
      t++;
      if (t > 2000) begin $display("FAIL result_timeout: sent %0d of %0d words", sent, n + 1); $fatal(1); end
    end
    bus.i_out_ready = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.i_start = 1'b0; bus.i_sub = 1'b0; bus.i_varsize = '0;
    bus.i_x1addr = '0; bus.i_x2addr = '0; bus.i_x3addr = '0;
    bus.i_in_valid = 1'b0; bus.i_in_data = '0; bus.i_out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin op1[i] = '0; op2[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    op1[0] = 16'hFFFF; op1[1] = 16'h0001; op2[0] = 16'h0001; op2[1] = 16'h0000; lit = 1;
    run(1'b0, 32, 0, 0, 3, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin op1[i] = '0; op2[i] = '0; end
    op1[0] = 16'h0005; op2[0] = 16'h0007; lit = 2;
    run(1'b1, 17, 0, 0, 2, 1'b0, 1'b0);
    lit = 0;
    rand_ops(); run(1'b0, 48, 0, 1, 1, 1'b0, 1'b0);
    rand_ops(); run(1'b1, 40, 1, 0, 2, 1'b0, 1'b0);
    rand_ops(); run(1'b0, 33, 2, 0, 0, 1'b1, 1'b0);
    bus.i_start = 1'b1; bus.i_varsize = '0;
    repeat (3) @(posedge clk);
    #1 bus.i_start = 1'b0;
    rand_ops(); run(1'b0, 40, 0, 0, 1, 1'b0, 1'b1);
    @(posedge clk); #1;
    rand_ops(); run(1'b1, 36, 0, 0, 2, 1'b0, 1'b0);
    rand_ops(); run(1'b0, 16, 0, 0, 0, 1'b0, 1'b0);
    rand_ops(); run(1'b1, 1, 2, 0, 1, 1'b0, 1'b0);
    rand_ops(); run(1'b0, 64, 2, 1, 4, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++) begin
      rand_ops();
      run(1'($urandom), $urandom_range(1, 128), $urandom_range(0, 2), $urandom_range(0, 1),
          $urandom_range(0, 4), 1'($urandom), 1'b0);
      if ($urandom_range(0, 1) != 0) begin @(posedge clk); #1; end
    end
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
